serial_fa_adder: RTL and testbench
==================================

Name: serial_fa_adder

Overview:
Parametrised, bit-serial successor to the team's single-bit combinational full adder. It adds or subtracts two WIDTH-bit operands using one full-adder cell and a carry flip-flop, processing one bit per clock, LSB first. It uses a start/busy/done handshake and holds its result registers so board LEDs or downstream logic can read them. It sits between the PMOD operand/switch capture logic and the LED/result display logic.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request to begin an operation; sampled only in IDLE.
sub  input  1  operation select, sampled with start: 0 = a+b, 1 = a-b.
a  input  WIDTH  operand A, sampled with start.
b  input  WIDTH  operand B, sampled with start.
busy  output  1  high while state is RUN.
done  output  1  single-cycle pulse when a result is committed.
sum  output  WIDTH  result register; holds its value until the next commit.
cout  output  1  carry out of the MSB; for subtraction, 1 means no borrow.
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy, done, sum, cout and ovf all 0; shift registers, counter and carry all 0.
- IDLE, start = 1 at edge E0:
  - load a_sr <= a.
  - load b_sr <= b, or ~b when sub = 1.
  - load carry <= sub.
  - cnt <= 0; go to RUN.
- RUN, each edge, using s and c from the full-adder cell on (a_sr[0], b_sr[0], carry):
  - res_sr <= {s, res_sr[WIDTH-1:1]}.
  - carry <= c.
  - a_sr and b_sr shift right by 1.
  - cnt <= cnt + 1.
- RUN, on the edge where cnt == WIDTH-1:
  - sum <= {s, res_sr[WIDTH-1:1]}.
  - cout <= c.
  - ovf <= carry ^ c (carry here is the carry into the MSB).
  - go to DONE.
- DONE: done = 1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: start sampled at E0; the result is committed at edge E(WIDTH) and done is high for the following cycle. The next start can be accepted at E(WIDTH+2).
- busy = (state == RUN). done = (state == DONE). Both are decoded from registered state, so there are no combinational paths from the inputs.
- Inputs start, sub, a and b are ignored in RUN and DONE. Operand changes during RUN do not affect the result in progress.
- start held high continuously: back-to-back operations, one every WIDTH+2 cycles.
- rst_n asserted mid-RUN: the operation is aborted, done is never pulsed, and sum keeps its reset value of 0.
- Arithmetic is modulo 2^WIDTH. The result is identical to a parallel WIDTH-bit add/subtract with carry-in = sub.

Decomposition:
- Shared package: state encoding IDLE/RUN/DONE as 2-bit localparams, and the OP_ADD = 0 / OP_SUB = 1 constants.
- One sub-module, fa_cell: purely combinational full adder with inputs x, y, ci and outputs s = x^y^ci, co = majority(x, y, ci). It is instantiated once.
- The FSM, counter and shift registers stay in serial_fa_adder.

Test Plan:
1. WIDTH=4, a=5, b=3, sub=0 -> done pulses on the 5th edge after start; sum=8, cout=0, ovf=1; busy high for exactly 4 cycles.
2. WIDTH=4, a=7, b=9, sub=0 -> sum=0, cout=1, ovf=0.
3. WIDTH=4, a=3, b=5, sub=1 -> sum=14 (-2), cout=0 (borrow), ovf=0. Then a=5, b=3, sub=1 -> sum=2, cout=1, ovf=0.
4. WIDTH=8, a=200, b=100, sub=0 -> sum=44, cout=1, ovf=0. Then pulse start and change a/b mid-RUN -> result unchanged and the extra start is ignored.
5. WIDTH=8, start, then drop rst_n for 1 cycle on the 4th RUN cycle -> busy=0, done never asserted, sum=0; the next operation (a=1, b=1) yields sum=2.
6. Random sweep, WIDTH=8, 1000 operations with random sub and back-to-back starts -> sum, cout and ovf match the reference model: parallel (a + (sub ? ~b : b) + sub), with ovf = carry into MSB XOR carry out.

Source files
------------

// File: rtl/serial_fa_adder_pkg.sv
// rtl/serial_fa_adder_pkg.sv - shared constants for the bit-serial adder/subtractor
// Purpose: state encoding and operation-select constants used by the
//          serial adder and its full-adder cell.
// Ports:   none (package).
package serial_fa_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_fa_adder_fa_cell.sv
// rtl/serial_fa_adder_fa_cell.sv - single-bit combinational full adder
// Purpose: one full-adder cell, reused every clock by the serial adder.
// Ports:   x, y, ci - addend bits and carry in
//          s        - sum bit (x ^ y ^ ci)
//          co       - carry out (majority of x, y, ci)
module fa_cell
  import serial_fa_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_fa_adder.sv
// rtl/serial_fa_adder.sv - bit-serial WIDTH-bit adder/subtractor, LSB first
// Purpose: adds or subtracts two operands one bit per clock through a single
//          full-adder cell and a carry flop, with a start/busy/done handshake
//          and held result registers.
// Ports:   clk, rst_n   - clock, asynchronous active-low reset
//          start        - begin an operation (sampled only in IDLE)
//          sub          - 0 = a+b, 1 = a-b (sampled with start)
//          a, b         - operands (sampled with start)
//          busy         - high while running
//          done         - one-cycle pulse when the result is committed
//          sum          - result, held until the next commit
//          cout         - carry out of MSB (for subtraction 1 = no borrow)
//          ovf          - two's-complement overflow
module serial_fa_adder
  import serial_fa_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic fa_s;
  logic fa_c;

  fa_cell u_fa_cell (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          b_sr_d  = (sub == OP_SUB) ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};
        carry_d  = fa_c;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {fa_s, res_sr_q[WIDTH-1:1]};
          cout_d  = fa_c;
          // carry_q is the carry into the MSB on this last bit.
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_fa_adder.sv
// tb/tb_serial_fa_adder.sv - directed and random checks of serial_fa_adder at WIDTH 4 and 8
module tb_serial_fa_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       busy4, done4, cout4, ovf4;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, cout8, ovf8;

  serial_fa_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_fa_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  // Drives one WIDTH=4 operation; returns at the negedge where done is seen.
  task automatic op4(input logic [3:0] ai, input logic [3:0] bi, input logic si,
                     output logic [3:0] so, output logic co, output logic vo,
                     output int lat, output int bcnt);
    @(negedge clk);
    a4 = ai; b4 = bi; sub4 = si; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    lat = 0; bcnt = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      if (busy4 === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    so = sum4; co = cout4; vo = ovf4;
  endtask

  // Same for WIDTH=8; with disturb set, operands and start are wiggled mid-RUN.
  task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic si,
                     input logic disturb,
                     output logic [7:0] so, output logic co, output logic vo,
                     output int lat);
    @(negedge clk);
    a8 = ai; b8 = bi; sub8 = si; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (disturb && lat == 2) begin
        a8 = 8'hFF; b8 = 8'h55; sub8 = 1'b1; start8 = 1'b1;
      end
      if (disturb && lat == 3) start8 = 1'b0;
      @(negedge clk);
      lat++;
    end
    so = sum8; co = cout8; vo = ovf8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin bad++; $display("FAIL reset_ctrl4 busy=%b done=%b want 0 0", busy4, done4); end
    total++; if (sum4 !== 4'd0 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin bad++; $display("FAIL reset_res4 sum=%0d cout=%b ovf=%b want 0 0 0", sum4, cout4, ovf4); end
    total++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin bad++; $display("FAIL reset_ctrl8 busy=%b done=%b want 0 0", busy8, done8); end
    total++; if (sum8 !== 8'd0 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin bad++; $display("FAIL reset_res8 sum=%0d cout=%b ovf=%b want 0 0 0", sum8, cout8, ovf8); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add4_ovf();
    logic [3:0] s; logic c, v; int lat, bc;
    op4(4'd5, 4'd3, 1'b0, s, c, v, lat, bc);
    total++; if (lat !== 4) begin bad++; $display("FAIL add4_latency got=%0d want=4", lat); end
    total++; if (bc !== 4) begin bad++; $display("FAIL add4_busy_cycles got=%0d want=4", bc); end
    total++; if (s !== 4'd8) begin bad++; $display("FAIL add4_sum got=%0d want=8", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL add4_cout got=%b want=0", c); end
    total++; if (v !== 1'b1) begin bad++; $display("FAIL add4_ovf got=%b want=1", v); end
    @(negedge clk);
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL add4_done_width got=%b want=0", done4); end
    total++; if (sum4 !== 4'd8) begin bad++; $display("FAIL add4_sum_hold got=%0d want=8", sum4); end
  endtask

  task automatic test_add4_carry();
    logic [3:0] s; logic c, v; int lat, bc;
    op4(4'd7, 4'd9, 1'b0, s, c, v, lat, bc);
    total++; if (s !== 4'd0) begin bad++; $display("FAIL carry4_sum got=%0d want=0", s); end
    total++; if (c !== 1'b1) begin bad++; $display("FAIL carry4_cout got=%b want=1", c); end
    total++; if (v !== 1'b0) begin bad++; $display("FAIL carry4_ovf got=%b want=0", v); end
  endtask

  task automatic test_sub4();
    logic [3:0] s; logic c, v; int lat, bc;
    op4(4'd3, 4'd5, 1'b1, s, c, v, lat, bc);
    total++; if (s !== 4'd14) begin bad++; $display("FAIL sub4_neg_sum got=%0d want=14", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL sub4_neg_cout got=%b want=0", c); end
    total++; if (v !== 1'b0) begin bad++; $display("FAIL sub4_neg_ovf got=%b want=0", v); end
    op4(4'd5, 4'd3, 1'b1, s, c, v, lat, bc);
    total++; if (s !== 4'd2) begin bad++; $display("FAIL sub4_pos_sum got=%0d want=2", s); end
    total++; if (c !== 1'b1) begin bad++; $display("FAIL sub4_pos_cout got=%b want=1", c); end
    total++; if (v !== 1'b0) begin bad++; $display("FAIL sub4_pos_ovf got=%b want=0", v); end
  endtask

  task automatic test_add8_ignore();
    logic [7:0] s; logic c, v; int lat; int busy_seen;
    op8(8'd200, 8'd100, 1'b0, 1'b0, s, c, v, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL add8_latency got=%0d want=8", lat); end
    total++; if (s !== 8'd44 || c !== 1'b1 || v !== 1'b0) begin bad++; $display("FAIL add8_result sum=%0d cout=%b ovf=%b want 44 1 0", s, c, v); end
    op8(8'd200, 8'd100, 1'b0, 1'b1, s, c, v, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL ignore8_latency got=%0d want=8", lat); end
    total++; if (s !== 8'd44 || c !== 1'b1 || v !== 1'b0) begin bad++; $display("FAIL ignore8_result sum=%0d cout=%b ovf=%b want 44 1 0", s, c, v); end
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy8 === 1'b1) busy_seen++;
    end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL ignore8_extra_start busy_cycles=%0d want=0", busy_seen); end
  endtask

  task automatic test_abort();
    logic [7:0] s; logic c, v; int lat; int done_seen;
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL abort_running busy=%b want=1", busy8); end
    rst_n = 1'b0;
    #1;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy8); end
    total++; if (sum8 !== 8'd0 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin bad++; $display("FAIL abort_regs sum=%0d cout=%b ovf=%b want 0 0 0", sum8, cout8, ovf8); end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8 === 1'b1) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL abort_no_done count=%0d want=0", done_seen); end
    total++; if (sum8 !== 8'd0) begin bad++; $display("FAIL abort_sum_kept got=%0d want=0", sum8); end
    op8(8'd1, 8'd1, 1'b0, 1'b0, s, c, v, lat);
    total++; if (s !== 8'd2 || c !== 1'b0 || v !== 1'b0) begin bad++; $display("FAIL abort_next_op sum=%0d cout=%b ovf=%b want 2 0 0", s, c, v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ra, rb, bb, low;
    logic       rs, exp_c, exp_v;
    logic [8:0] full;
    int lat;
    start8 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      a8 = ra; b8 = rb; sub8 = rs;
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        @(negedge clk);
        lat++;
      end
      bb    = rs ? ~rb : rb;
      full  = {1'b0, ra} + {1'b0, bb} + 9'(rs);
      low   = {1'b0, ra[6:0]} + {1'b0, bb[6:0]} + 8'(rs);
      exp_c = full[8];
      exp_v = low[7] ^ full[8];
      total++; if (lat !== 8) begin bad++; $display("FAIL b2b_latency op=%0d got=%0d want=8", n, lat); end
      total++; if (sum8 !== full[7:0]) begin bad++; $display("FAIL b2b_sum op=%0d a=%0d b=%0d sub=%b got=%0d want=%0d", n, ra, rb, rs, sum8, full[7:0]); end
      total++; if (cout8 !== exp_c) begin bad++; $display("FAIL b2b_cout op=%0d got=%b want=%b", n, cout8, exp_c); end
      total++; if (ovf8 !== exp_v) begin bad++; $display("FAIL b2b_ovf op=%0d got=%b want=%b", n, ovf8, exp_v); end
      if (lat >= 40) break;
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add4_ovf();
    test_add4_carry();
    test_sub4();
    test_add8_ignore();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
